// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states and
// the default operand width.
package mdu_pkg;

    localparam int BUS_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_addsub.sv
// BUS_W+1-bit adder/subtractor shared by the shift-add multiply and the
// restoring divide. cout=1 on subtract means "no borrow" (a >= b).
module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int BUS_W = BUS_W_DEF
) (
    input  logic [BUS_W:0] a,
    input  logic [BUS_W:0] b,
    input  logic           sub,
    output logic [BUS_W:0] y,
    output logic           cout
);

    logic [BUS_W+1:0] total;

    // a + b, or a + ~b + 1 for subtraction, with the carry kept
    always_comb begin
        total = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(BUS_W + 1){1'b0}}, sub};
        y     = total[BUS_W:0];
        cout  = total[BUS_W + 1];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle.
// Operands are reduced to magnitudes on start, processed unsigned in CALC,
// and the sign is restored in FIX before hi/lo are loaded.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | BUS_W shift-add / shift-subtract iterations
// FIX   | sign correction, hi/lo loaded on exit
// DONE  | result valid for one cycle, start accepted here too
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int BUS_W = BUS_W_DEF,
    parameter int OP_W  = 2
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [BUS_W-1:0] rs_data,
    input  logic [BUS_W-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [BUS_W-1:0] hi,
    output logic [BUS_W-1:0] lo
);

    localparam int AW = 2 * BUS_W + 1;
    localparam int PW = 2 * BUS_W;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    acc;
    logic [BUS_W-1:0] opnd_q;
    logic [BUS_W-1:0] dividend_q;
    logic             is_div_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic [5:0]       cnt;

    logic             start_ok;
    logic             in_div;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [BUS_W-1:0] a_mag;
    logic [BUS_W-1:0] b_mag;

    logic [BUS_W:0]   as_a;
    logic [BUS_W:0]   as_b;
    logic [BUS_W:0]   as_y;
    logic             as_cout;

    logic [PW-1:0]    prod;
    logic [BUS_W-1:0] quo;
    logic [BUS_W-1:0] rem;
    logic [BUS_W-1:0] res_hi;
    logic [BUS_W-1:0] res_lo;

    // Start qualification, opcode decode and operand magnitudes
    always_comb begin
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
        in_div    = (op == OP_W'(OP_DIV)) || (op == OP_W'(OP_DIVU));
        in_signed = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_DIV));
        a_neg     = in_signed && rs_data[BUS_W-1];
        b_neg     = in_signed && rt_data[BUS_W-1];
        a_mag     = a_neg ? (~rs_data + BUS_W'(1)) : rs_data;
        b_mag     = b_neg ? (~rt_data + BUS_W'(1)) : rt_data;
    end

    // Adder operands: divide subtracts the divisor from the shifted partial
    // remainder; multiply adds the multiplicand when the current bit is set.
    always_comb begin
        as_a = is_div_q ? acc[PW-1:BUS_W-1] : acc[AW-1:BUS_W];
        as_b = {1'b0, ((is_div_q || acc[0]) ? opnd_q : {BUS_W{1'b0}})};
    end

    mdu_addsub #(
        .BUS_W (BUS_W)
    ) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (is_div_q),
        .y    (as_y),
        .cout (as_cout)
    );

    // Operand latch and iteration datapath
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            cnt        <= '0;
        end else if (start_ok) begin
            is_div_q   <= in_div;
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            dz_q       <= in_div && (rt_data == '0);
            dividend_q <= rs_data;
            opnd_q     <= in_div ? b_mag : a_mag;
            acc        <= {{(BUS_W + 1){1'b0}}, (in_div ? a_mag : b_mag)};
            cnt        <= '0;
        end else if (state == ST_CALC) begin
            cnt <= cnt + 6'd1;
            if (is_div_q) begin
                acc <= {(as_cout ? as_y : as_a), acc[BUS_W-2:0], as_cout};
            end else begin
                acc <= {as_cout, as_y, acc[BUS_W-1:1]};
            end
        end
    end

    // Sign restoration and divide-by-zero override
    always_comb begin
        prod   = acc[PW-1:0];
        quo    = acc[BUS_W-1:0];
        rem    = acc[PW-1:BUS_W];
        res_hi = '0;
        res_lo = '0;
        if (dz_q) begin
            res_hi = dividend_q;
            res_lo = '1;
        end else if (is_div_q) begin
            res_lo = neg_q ? (~quo + BUS_W'(1)) : quo;
            res_hi = rem_neg_q ? (~rem + BUS_W'(1)) : rem;
        end else begin
            {res_hi, res_lo} = neg_q ? (~prod + PW'(1)) : prod;
        end
    end

    // Result registers load on the edge into DONE and hold afterwards
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

    // FSM state register
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = start ? ST_CALC : ST_IDLE;
            ST_CALC:          state_nxt = (cnt == 6'(BUS_W - 1)) ? ST_FIX : ST_CALC;
            ST_FIX:           state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from state only
    always_comb begin
        busy     = (state == ST_CALC) || (state == ST_FIX);
        done     = (state == ST_DONE);
        div_zero = (state == ST_DONE) && dz_q;
    end

endmodule
